enc_16x4: RTL

ENC_16X4 -- requirements
Module: enc_16x4

---
 rtl/enc_pkg.sv | 27 ++
 rtl/prio_enc16.sv | 23 ++
 rtl/enc_16x4.sv | 102 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and small helpers for the 16-to-4 request encoder.
package enc_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } enc_state_e;

    // Same mapping as the existing 4x16 decoder: index -> one-hot bit.
    function automatic logic [N_REQ-1:0] dec4x16(input logic [IDX_W-1:0] idx);
        dec4x16 = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [CNT_W-1:0] popcount16(input logic [N_REQ-1:0] mask);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-bit priority encoder; HIGH_FIRST selects which end of the mask wins.
module prio_enc16
    import enc_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [N_REQ-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scan from the losing end toward the winning end so the last hit is the winner.
    always_comb begin
        idx     = {IDX_W{1'b0}};
        any_set = |mask;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j   = HIGH_FIRST ? i : (N_REQ - 1 - i);
            idx = mask[j] ? IDX_W'(j) : idx;
        end
    end

endmodule

// File: rtl/enc_16x4.sv
// Pending-request tracker that presents one priority-encoded index at a time
// over a valid/ready handshake, with popcount and lost-request reporting.
module enc_16x4
    import enc_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [N_REQ-1:0] pending_out,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow
);

    enc_state_e       state_r;
    enc_state_e       next_state_s;
    logic [N_REQ-1:0] pending_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] next_idx_s;
    logic [IDX_W-1:0] idx_cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic             overflow_r;

    logic             handshake_s;
    logic [N_REQ-1:0] ack_mask_s;
    logic [N_REQ-1:0] next_pending_s;
    logic             overflow_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_any_s;

    // A same-cycle request on the acked bit is OR-ed back in after the clear, so it survives.
    assign handshake_s    = (state_r == ST_PRESENT) && idx_ready;
    assign ack_mask_s     = handshake_s ? dec4x16(idx_r) : {N_REQ{1'b0}};
    assign next_pending_s = (pending_r & ~ack_mask_s) | req_in;
    assign overflow_s     = |(req_in & pending_r & ~ack_mask_s);

    prio_enc16 #(
        .HIGH_FIRST(HIGH_FIRST)
    ) u_prio (
        .mask    (next_pending_s),
        .idx     (enc_idx_s),
        .any_set (enc_any_s)
    );

    // Next-state and next-index selection for the presentation FSM.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (|pending_r) begin
                    next_idx_s   = idx_cand_r;
                    next_state_s = ST_PRESENT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (handshake_s) begin
                    next_idx_s   = enc_any_s ? enc_idx_s : idx_r;
                    next_state_s = enc_any_s ? ST_PRESENT : ST_IDLE;
                end else begin
                    next_state_s = ST_PRESENT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_idx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, pending mask and all registered outputs; idx_cand_r is the encoding of pending_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pending_r  <= {N_REQ{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            idx_cand_r <= {IDX_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            pending_r  <= next_pending_s;
            idx_r      <= next_idx_s;
            idx_cand_r <= enc_idx_s;
            cnt_r      <= popcount16(next_pending_s);
            overflow_r <= overflow_s;
        end
    end

    assign idx_out     = idx_r;
    assign idx_valid   = (state_r == ST_PRESENT);
    assign pending_out = pending_r;
    assign pending_cnt = cnt_r;
    assign overflow    = overflow_r;

endmodule
